varint_enc_0: RTL and testbench
===============================

// Module: varint_enc_0
// PURPOSE
//  Consumer stage for the varint input FIFO pair (data + index) loaded by the AXI4 write-slave FSM.
//  Pops one {value, index} entry at a time and encodes the value as an unsigned LEB128/protobuf varint.
//  Emits the encoding as a byte stream (valid/ready), least-significant 7-bit group first.
//  Each byte is tagged with the entry's index and a last-byte flag for the downstream serializer.
// PARAMETERS
//  DATA_WIDTH   32  width of FIFO value; legal values are 32 and 64 (max 5 or 10 bytes per varint)
//  INDEX_WIDTH  10  width of the index tag carried from the index FIFO
// PORTS
//  clk                  in   1            system clock
//  reset                in   1            synchronous, active-high reset
//  enc_clr              in   1            synchronous abort; same state effect as reset, counters kept
//  varint_in_fifo_empty in   1            data FIFO empty (index FIFO is pushed in lockstep)
//  varint_in_fifo_data  in   DATA_WIDTH   head-of-FIFO value (first-word-fall-through)
//  varint_in_index_data in   INDEX_WIDTH  head-of-FIFO index (first-word-fall-through)
//  varint_in_fifo_pop   out  1            pop data FIFO head (one cycle per entry)
//  varint_in_index_pop  out  1            pop index FIFO head; always equal to varint_in_fifo_pop
//  out_valid            out  1            byte available
//  out_ready            in   1            downstream accepts byte
//  out_data             out  8            {continuation bit, 7 value bits}
//  out_last             out  1            final byte of this varint (continuation bit = 0)
//  out_index            out  INDEX_WIDTH  index of the entry being emitted
//  busy                 out  1            high whenever state != IDLE
//  bytes_out            out  32           count of accepted bytes, wraps 2^32-1 -> 0
//  values_out           out  32           count of completed varints, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including bytes_out, values_out and the internal shift register.
//  FIFO read protocol: data and index are valid while !empty; a pop advances both FIFOs next cycle.
//  Pop fires only when !empty; a pop never coincides with reset or enc_clr.
//  States:
//   IDLE: out_valid=0. If !empty: pop=1; capture data into shift reg sr and index into out_index; go EMIT.
//   EMIT: out_valid=1; out_data={more, sr[6:0]}, where more=(sr>>7)!=0; out_last=~more.
//    valid&&ready&&more: sr<=sr>>7; stay in EMIT.
//    valid&&ready&&~more&&!empty: pop, load next entry; stay in EMIT.
//     This gives back-to-back entries with no bubble cycle.
//    valid&&ready&&~more&&empty: go IDLE.
//    valid&&~ready: out_data, out_last and out_index held stable; out_valid stays high.
//  Latency: first byte is valid 1 cycle after the pop cycle.
//  Throughput: 1 byte/cycle with out_ready high.
//  Byte count per varint: 1 + floor(msb_pos/7); value 0 -> single byte 0x00 with out_last=1.
//  DATA_WIDTH=32 gives 1..5 bytes; the final byte of 0xFFFFFFFF is 0x0F.
//  Counters: bytes_out +1 on every valid&&ready; values_out +1 on valid&&ready&&out_last.
//  enc_clr: next cycle state IDLE, out_valid=0, sr=0, no pop. Counters are not cleared.
//   A byte accepted in the enc_clr cycle is still counted.
//  Reset mid-operation: immediate return to reset values. The partially emitted varint is dropped.
//  Invalid state encoding -> IDLE.
// TESTING
//  T1: FIFO {0x00000001, idx 3} -> one byte 0x01, last=1, index=3; values_out=1.
//  T2: value 300 (0x12C), ready high -> 0xAC then 0x02(last); the two bytes are in consecutive cycles.
//  T3: 0xFFFFFFFF -> FF FF FF FF 0F, last only on 0x0F; 0x00000000 -> single 0x00 last.
//  T4: value 0x4000 with out_ready low 5 cycles on byte 2 -> 0x80, 0x80, 0x01.
//   Held bytes stay stable during the stall; no extra pops occur.
//  T5: two queued entries {0x7F, idx 1} and {0x80, idx 2}, ready high
//   -> 0x7F(last,1), 0x80(2), 0x01(last,2), with no idle cycle; exactly 2 pops.
//  T6: enc_clr asserted after the 2nd byte of 0xFFFFFFFF -> out_valid=0 next cycle; bytes_out=2.
//   The next FIFO entry is then encoded normally.
//   Repeat the sequence with reset in place of enc_clr: counters return to 0.

Source files
------------

// File: rtl/varint_enc_0.sv
// LEB128 varint encoder: pops {value, index} FIFO entries and streams
// the encoding LSB group first, one byte per handshake.
module varint_enc_0 #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enc_clr,
    input  logic                   varint_in_fifo_empty,
    input  logic [DATA_WIDTH-1:0]  varint_in_fifo_data,
    input  logic [INDEX_WIDTH-1:0] varint_in_index_data,
    output logic                   varint_in_fifo_pop,
    output logic                   varint_in_index_pop,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic                   out_last,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic                   busy,
    output logic [31:0]            bytes_out,
    output logic [31:0]            values_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1
    } state_t;

    state_t                 state, state_nxt;
    logic [DATA_WIDTH-1:0]  sr, sr_nxt;
    logic [INDEX_WIDTH-1:0] idx_q, idx_nxt;
    logic                   more;
    logic                   accept;
    logic                   pop;

    assign more      = |sr[DATA_WIDTH-1:7];
    assign out_valid = (state == EMIT);
    assign out_data  = out_valid ? {more, sr[6:0]} : 8'd0;
    assign out_last  = out_valid & ~more;
    assign out_index = idx_q;
    assign busy      = (state != IDLE);
    assign accept    = out_valid & out_ready;

    assign varint_in_fifo_pop  = pop;
    assign varint_in_index_pop = pop;

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        idx_nxt   = idx_q;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!varint_in_fifo_empty) begin
                    pop       = 1'b1;
                    sr_nxt    = varint_in_fifo_data;
                    idx_nxt   = varint_in_index_data;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (accept) begin
                    if (more) begin
                        sr_nxt = sr >> 7;
                    end else if (!varint_in_fifo_empty) begin
                        // chain straight into the next entry, no bubble
                        pop     = 1'b1;
                        sr_nxt  = varint_in_fifo_data;
                        idx_nxt = varint_in_index_data;
                    end else begin
                        sr_nxt    = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                sr_nxt    = '0;
                state_nxt = IDLE;
            end
        endcase
        if (reset || enc_clr) begin
            pop       = 1'b0;
            sr_nxt    = '0;
            idx_nxt   = '0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= '0;
            idx_q      <= '0;
            bytes_out  <= '0;
            values_out <= '0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            idx_q <= idx_nxt;
            if (accept) begin
                bytes_out <= bytes_out + 32'd1;
            end
            if (accept && out_last) begin
                values_out <= values_out + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_varint_enc_0.sv
// Scoreboard bench for varint_enc_0: a FIFO model feeds the encoder and a
// monitor compares each accepted byte against an arithmetic LEB128 model.
module tb_varint_enc_0;
    localparam int DW = 32;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enc_clr = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic [IW-1:0] index_data = '0;
    logic          fifo_pop, index_pop;
    logic          out_valid, out_last, busy;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic [IW-1:0] out_index;
    logic [31:0]   bytes_out, values_out;

    always #5 clk = ~clk;

    varint_enc_0 #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
        .clk(clk),
        .reset(reset),
        .enc_clr(enc_clr),
        .varint_in_fifo_empty(fifo_empty),
        .varint_in_fifo_data(fifo_data),
        .varint_in_index_data(index_data),
        .varint_in_fifo_pop(fifo_pop),
        .varint_in_index_pop(index_pop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .out_index(out_index),
        .busy(busy),
        .bytes_out(bytes_out),
        .values_out(values_out)
    );

    typedef struct packed {
        logic [7:0]    d;
        logic          last;
        logic [IW-1:0] idx;
    } byte_t;

    typedef struct packed {
        logic [DW-1:0] v;
        logic [IW-1:0] idx;
    } ent_t;

    byte_t exp_q[$];
    ent_t  fifo_q[$];
    int    total = 0;
    int    bad = 0;
    int    acc = 0;
    int    lasts = 0;
    int    pops = 0;
    int    acc_t[0:8191];
    int    pop_t[0:8191];
    bit    pop_pend = 0;
    bit    stall_prev = 0;
    byte_t held;
    byte_t got;
    byte_t e;
    ent_t  tmp;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: split the value into 7-bit groups with plain arithmetic
    task automatic push_val(input logic [DW-1:0] v, input logic [IW-1:0] idx);
        logic [DW-1:0] r;
        byte_t b;
        fifo_q.push_back('{v: v, idx: idx});
        r = v;
        do begin
            b.d[6:0] = 7'(r % 128);
            r        = r / 128;
            b.d[7]   = (r != 0);
            b.last   = (r == 0);
            b.idx    = idx;
            exp_q.push_back(b);
        end while (r != 0);
    endtask

    // FIFO head model (first-word-fall-through)
    always @(negedge clk) begin
        #1;
        if (pop_pend) begin
            if (fifo_q.size() > 0) tmp = fifo_q.pop_front();
            pop_pend = 0;
        end
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0].v;
        index_data = fifo_empty ? '0 : fifo_q[0].idx;
    end

    // Monitor: samples two time units before the rising edge
    always @(negedge clk) begin
        #3;
        chk("pop_pair", index_pop, fifo_pop);
        if (fifo_pop) begin
            chk("pop_when_empty", fifo_empty, 0);
            chk("pop_in_clear", reset | enc_clr, 0);
            pop_t[pops] = int'($time / 10);
            pops++;
            pop_pend = 1;
        end
        if (reset) begin
            acc = 0;
            lasts = 0;
            stall_prev = 0;
        end else begin
            chk("bytes_out", bytes_out, acc);
            chk("values_out", values_out, lasts);
            chk("busy", busy, out_valid);
            got = '{d: out_data, last: out_last, idx: out_index};
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", got, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_byte: got %0h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_data", got.d, e.d);
                    chk("byte_last", got.last, e.last);
                    chk("byte_index", got.idx, e.idx);
                end
                acc_t[acc] = int'($time / 10);
                acc++;
                if (out_last) lasts++;
            end
            stall_prev = out_valid && !out_ready && !enc_clr;
            held = got;
        end
    end

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 2000, 1);
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", n < 500, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int p;
        int nb;
        logic [DW-1:0] v;

        repeat (3) @(negedge clk);
        reset = 0;
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_index", out_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bytes", bytes_out, 0);
        chk("rst_values", values_out, 0);
        chk("rst_pop", fifo_pop, 0);

        // single-byte value, first-byte latency
        @(negedge clk);
        out_ready = 1;
        b = acc;
        p = pops;
        push_val(32'd1, 10'd3);
        drain();
        chk("t1_values_out", values_out, 1);
        chk("t1_latency", acc_t[b] - pop_t[p], 1);

        // 300 -> AC 02 in consecutive cycles
        b = acc;
        push_val(32'd300, 10'd5);
        drain();
        chk("t2_consec", acc_t[b + 1] - acc_t[b], 1);

        // widest and zero values
        b = acc;
        push_val(32'hFFFF_FFFF, 10'd7);
        push_val(32'h0, 10'd8);
        drain();
        chk("t3_bytes", acc - b, 6);

        // stall on the second byte
        b = acc;
        p = pops;
        push_val(32'h4000, 10'd9);
        wait_acc(b + 1);
        out_ready = 0;
        repeat (5) @(negedge clk);
        chk("t4_no_pop", pops - p, 1);
        out_ready = 1;
        drain();
        chk("t4_bytes", acc - b, 3);

        // two queued entries, no bubble
        b = acc;
        p = pops;
        push_val(32'h7F, 10'd1);
        push_val(32'h80, 10'd2);
        drain();
        chk("t5_pops", pops - p, 2);
        chk("t5_no_bubble", acc_t[b + 2] - acc_t[b], 2);

        // abort mid-varint with enc_clr
        b = acc;
        push_val(32'hFFFF_FFFF, 10'd11);
        wait_acc(b + 2);
        out_ready = 0;
        enc_clr = 1;
        @(negedge clk);
        enc_clr = 0;
        #2;
        chk("t6_clr_valid", out_valid, 0);
        chk("t6_clr_busy", busy, 0);
        chk("t6_clr_bytes", bytes_out, b + 2);
        exp_q.delete();
        out_ready = 1;
        push_val(32'h55, 10'd12);
        drain();

        // same abort with reset: counters return to zero
        b = acc;
        push_val(32'hFFFF_FFFF, 10'd13);
        wait_acc(b + 2);
        out_ready = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        #2;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_bytes", bytes_out, 0);
        chk("t6_rst_values", values_out, 0);
        exp_q.delete();
        out_ready = 1;
        push_val(32'h3FFF, 10'd14);
        drain();
        chk("t6_rst_bytes2", bytes_out, 2);
        chk("t6_rst_values2", values_out, 1);

        // random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 4) begin
                nb = $urandom_range(0, 32);
                v  = (nb == 0) ? '0 : ($urandom >> (32 - nb));
                push_val(v, 10'($urandom_range(0, 1023)));
            end
        end
        out_ready = 1;
        drain();
        chk("exp_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
